// File: rtl/bus_autoclear_timeout.sv
// Bus-mapped bank of autoclear channels: each channel is started by software, ends on
// done, stop or timeout, and records completion in history/timeout status registers.
module bus_autoclear_timeout #(
    parameter int AC_BITS_USED  = 4,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                    i_Bus_Clk,
    input  logic                    i_Bus_Rst,
    input  logic                    i_Bus_CS,
    input  logic                    i_Bus_Wr_Rd_n,
    input  logic [4:0]              i_Bus_Addr8,
    input  logic [15:0]             i_Bus_Wr_Data,
    output logic [15:0]             o_Bus_Rd_Data,
    output logic                    o_Bus_Rd_DV,
    output logic [AC_BITS_USED-1:0] o_AC_Start,
    input  logic [AC_BITS_USED-1:0] i_AC_Done,
    output logic                    o_AC_Irq
);

    localparam logic [4:0] ADDR_START = 5'h00;
    localparam logic [4:0] ADDR_BUSY  = 5'h02;
    localparam logic [4:0] ADDR_STOP  = 5'h04;
    localparam logic [4:0] ADDR_HIST  = 5'h06;
    localparam logic [4:0] ADDR_HCLR  = 5'h08;
    localparam logic [4:0] ADDR_TMO   = 5'h0A;
    localparam logic [4:0] ADDR_TSTAT = 5'h0C;
    localparam logic [4:0] ADDR_TCLR  = 5'h0E;
    localparam logic [4:0] ADDR_IEN   = 5'h10;

    typedef enum logic {IDLE, RUN} ch_state_t;

    ch_state_t                ch_state [AC_BITS_USED];
    logic [TIMEOUT_WIDTH-1:0] ch_cnt   [AC_BITS_USED];

    logic [AC_BITS_USED-1:0]  busy, hist, tstat, ien;
    logic [TIMEOUT_WIDTH-1:0] tmo, tmo_m1;
    logic                     wr_en, rd_en;
    logic [AC_BITS_USED-1:0]  wr_bits, start_req, stop_req, hclr_req, tclr_req;
    logic [AC_BITS_USED-1:0]  done_ev, tmo_ev;
    logic [15:0]              rd_mux;

    always_comb begin
        wr_en     = i_Bus_CS & i_Bus_Wr_Rd_n;
        rd_en     = i_Bus_CS & ~i_Bus_Wr_Rd_n;
        wr_bits   = i_Bus_Wr_Data[AC_BITS_USED-1:0];
        start_req = (wr_en && i_Bus_Addr8 == ADDR_START) ? wr_bits : '0;
        stop_req  = (wr_en && i_Bus_Addr8 == ADDR_STOP)  ? wr_bits : '0;
        hclr_req  = (wr_en && i_Bus_Addr8 == ADDR_HCLR)  ? wr_bits : '0;
        tclr_req  = (wr_en && i_Bus_Addr8 == ADDR_TCLR)  ? wr_bits : '0;
        tmo_m1    = tmo - TIMEOUT_WIDTH'(1);
        busy      = '0;
        done_ev   = '0;
        tmo_ev    = '0;
        // Events are resolved here in priority order so the FSM and the status
        // registers see one consistent outcome per channel: STOP > done > timeout.
        for (int unsigned n = 0; n < AC_BITS_USED; n++) begin
            busy[n]    = (ch_state[n] == RUN);
            done_ev[n] = busy[n] && !stop_req[n] && i_AC_Done[n];
            tmo_ev[n]  = busy[n] && !stop_req[n] && !i_AC_Done[n]
                         && (tmo != '0) && (ch_cnt[n] >= tmo_m1);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (i_Bus_Addr8)
            ADDR_BUSY:  rd_mux[AC_BITS_USED-1:0]  = busy;
            ADDR_HIST:  rd_mux[AC_BITS_USED-1:0]  = hist;
            ADDR_TMO:   rd_mux[TIMEOUT_WIDTH-1:0] = tmo;
            ADDR_TSTAT: rd_mux[AC_BITS_USED-1:0]  = tstat;
            ADDR_IEN:   rd_mux[AC_BITS_USED-1:0]  = ien;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_Bus_Clk or posedge i_Bus_Rst) begin
        if (i_Bus_Rst) begin
            o_AC_Start <= '0;
            for (int unsigned n = 0; n < AC_BITS_USED; n++) begin
                ch_state[n] <= IDLE;
                ch_cnt[n]   <= '0;
            end
        end else begin
            o_AC_Start <= '0;
            for (int unsigned n = 0; n < AC_BITS_USED; n++) begin
                if (ch_state[n] == IDLE) begin
                    if (start_req[n] && !stop_req[n]) begin
                        ch_state[n]   <= RUN;
                        ch_cnt[n]     <= '0;
                        o_AC_Start[n] <= 1'b1;
                    end
                end else if (stop_req[n] || done_ev[n] || tmo_ev[n]) begin
                    ch_state[n] <= IDLE;
                end else if (start_req[n]) begin
                    ch_cnt[n]     <= '0;
                    o_AC_Start[n] <= 1'b1;
                end else if (ch_cnt[n] != '1) begin
                    ch_cnt[n] <= ch_cnt[n] + TIMEOUT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge i_Bus_Clk or posedge i_Bus_Rst) begin
        if (i_Bus_Rst) begin
            hist          <= '0;
            tstat         <= '0;
            ien           <= '0;
            tmo           <= '0;
            o_AC_Irq      <= 1'b0;
            o_Bus_Rd_DV   <= 1'b0;
            o_Bus_Rd_Data <= '0;
        end else begin
            // Set terms are OR-ed after the clear so a same-cycle event wins.
            hist  <= (hist & ~hclr_req) | done_ev;
            tstat <= (tstat & ~tclr_req) | tmo_ev;
            if (wr_en && i_Bus_Addr8 == ADDR_IEN)
                ien <= wr_bits;
            if (wr_en && i_Bus_Addr8 == ADDR_TMO)
                tmo <= i_Bus_Wr_Data[TIMEOUT_WIDTH-1:0];
            o_AC_Irq      <= (|(hist & ien)) | (|tstat);
            o_Bus_Rd_DV   <= rd_en;
            o_Bus_Rd_Data <= rd_en ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_bus_autoclear_timeout.sv
// Directed bench for bus_autoclear_timeout with a timestamp-based reference model
// compared every cycle, plus literal register-read expectations.
module tb_bus_autoclear_timeout;

    localparam int AC = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs;
    logic          wr_rd_n;
    logic [4:0]    addr;
    logic [15:0]   wdata;
    logic [15:0]   rd_data;
    logic          rd_dv;
    logic [AC-1:0] ac_start;
    logic [AC-1:0] ac_done;
    logic          irq;

    int unsigned total = 0;
    int unsigned bad   = 0;

    bus_autoclear_timeout #(.AC_BITS_USED(AC), .TIMEOUT_WIDTH(TW)) dut (
        .i_Bus_Clk     (clk),
        .i_Bus_Rst     (rst),
        .i_Bus_CS      (cs),
        .i_Bus_Wr_Rd_n (wr_rd_n),
        .i_Bus_Addr8   (addr),
        .i_Bus_Wr_Data (wdata),
        .o_Bus_Rd_Data (rd_data),
        .o_Bus_Rd_DV   (rd_dv),
        .o_AC_Start    (ac_start),
        .i_AC_Done     (ac_done),
        .o_AC_Irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a channel is "running since edge t0"; cycles in run are
    // measured as elapsed edges, so timeout is simply elapsed >= TMO.
    int unsigned   cyc = 0;
    bit            m_run [AC];
    int unsigned   m_t0  [AC];
    logic [AC-1:0] m_hist = '0, m_tstat = '0, m_ien = '0;
    logic [TW-1:0] m_tmo = '0;
    logic          exp_dv = 1'b0, exp_irq = 1'b0;
    logic [15:0]   exp_data = '0;
    logic [AC-1:0] exp_start = '0;

    function automatic logic [15:0] model_read(input logic [4:0] a);
        logic [AC-1:0] runbits;
        for (int i = 0; i < AC; i++) runbits[i] = m_run[i];
        case (a)
            5'h02:   return 16'(runbits);
            5'h06:   return 16'(m_hist);
            5'h0A:   return 16'(m_tmo);
            5'h0C:   return 16'(m_tstat);
            5'h10:   return 16'(m_ien);
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        logic          w, r;
        logic [AC-1:0] wb, dset, tset;
        int unsigned   elapsed;
        cyc++;
        if (rst) begin
            for (int i = 0; i < AC; i++) begin m_run[i] = 1'b0; m_t0[i] = 0; end
            m_hist = '0; m_tstat = '0; m_ien = '0; m_tmo = '0;
            exp_dv = 1'b0; exp_data = '0; exp_start = '0; exp_irq = 1'b0;
        end else begin
            w  = cs & wr_rd_n;
            r  = cs & ~wr_rd_n;
            wb = wdata[AC-1:0];
            exp_dv    = r;
            exp_data  = r ? model_read(addr) : 16'h0000;
            exp_irq   = (|(m_hist & m_ien)) | (|m_tstat);
            exp_start = '0;
            dset = '0;
            tset = '0;
            for (int i = 0; i < AC; i++) begin
                logic st, sp;
                st = w && addr == 5'h00 && wb[i];
                sp = w && addr == 5'h04 && wb[i];
                if (m_run[i]) begin
                    elapsed = cyc - m_t0[i];
                    if (sp) m_run[i] = 1'b0;
                    else if (ac_done[i]) begin m_run[i] = 1'b0; dset[i] = 1'b1; end
                    else if (m_tmo != 0 && elapsed >= int'(m_tmo)) begin
                        m_run[i] = 1'b0; tset[i] = 1'b1;
                    end else if (st) begin m_t0[i] = cyc; exp_start[i] = 1'b1; end
                end else if (st && !sp) begin
                    m_run[i] = 1'b1; m_t0[i] = cyc; exp_start[i] = 1'b1;
                end
            end
            if (w && addr == 5'h08) m_hist  = m_hist & ~wb;
            if (w && addr == 5'h0E) m_tstat = m_tstat & ~wb;
            m_hist  = m_hist | dset;
            m_tstat = m_tstat | tset;
            if (w && addr == 5'h10) m_ien = wb;
            if (w && addr == 5'h0A) m_tmo = wdata[TW-1:0];
        end
    end

    always @(posedge clk) begin
        #1;
        total++;
        if ({rd_dv, rd_data, ac_start, irq} !== {exp_dv, exp_data, exp_start, exp_irq}) begin
            bad++;
            $display("FAIL model_cmp cyc=%0d got dv=%b data=%h start=%b irq=%b expected dv=%b data=%h start=%b irq=%b",
                     cyc, rd_dv, rd_data, ac_start, irq, exp_dv, exp_data, exp_start, exp_irq);
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [15:0] d);
        cs = 1'b1; wr_rd_n = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; wr_rd_n = 1'b0; wdata = '0;
    endtask

    task automatic bus_rd(input logic [4:0] a, input logic [15:0] exp, input string name);
        cs = 1'b1; wr_rd_n = 1'b0; addr = a;
        @(posedge clk);
        #1;
        check({name, "_dv"}, 16'(rd_dv), 16'h0001);
        check(name, rd_data, exp);
        @(negedge clk);
        cs = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; wr_rd_n = 1'b0; addr = '0; wdata = '0; ac_done = '0;
        repeat (3) tick();
        check("rst_dv", 16'(rd_dv), 16'h0000);
        check("rst_data", rd_data, 16'h0000);
        check("rst_start", 16'(ac_start), 16'h0000);
        check("rst_irq", 16'(irq), 16'h0000);
        rst = 1'b0;
        tick();

        // Basic start, single pulse, completion by done
        bus_wr(5'h00, 16'h0001);
        check("start_pulse_hi", 16'(ac_start), 16'h0001);
        tick();
        check("start_pulse_lo", 16'(ac_start), 16'h0000);
        bus_rd(5'h02, 16'h0001, "busy_run0");
        repeat (20) tick();
        ac_done = 4'b0001; tick(); tick(); ac_done = '0;
        bus_rd(5'h06, 16'h0001, "hist_done0");
        bus_rd(5'h02, 16'h0000, "busy_idle0");

        // Done interrupt and history clear
        bus_wr(5'h10, 16'h0001);
        bus_wr(5'h00, 16'h0001);
        repeat (3) tick();
        ac_done = 4'b0001; tick(); ac_done = '0;
        tick();
        check("irq_done", 16'(irq), 16'h0001);
        bus_wr(5'h08, 16'h0001);
        tick();
        check("irq_hclr", 16'(irq), 16'h0000);
        bus_rd(5'h06, 16'h0000, "hist_cleared");

        // Timeout of 10 cycles on channel 2
        bus_wr(5'h0A, 16'h000A);
        bus_wr(5'h00, 16'h0004);
        repeat (9) tick();
        bus_rd(5'h02, 16'h0004, "busy_tmo_last");
        bus_rd(5'h02, 16'h0000, "busy_tmo_drop");
        bus_rd(5'h0C, 16'h0004, "tstat_ch2");
        check("irq_tmo", 16'(irq), 16'h0001);
        bus_wr(5'h0E, 16'h0004);
        check("irq_tclr_lag", 16'(irq), 16'h0001);
        tick();
        check("irq_tclr", 16'(irq), 16'h0000);

        // STOP and done in the same cycle on different and on the same channel
        bus_wr(5'h0A, 16'h0000);
        bus_wr(5'h00, 16'h000A);
        tick(); tick();
        ac_done = 4'b1000; bus_wr(5'h04, 16'h0002); ac_done = '0;
        bus_rd(5'h02, 16'h0000, "busy_stopdone");
        bus_rd(5'h06, 16'h0008, "hist_stopdone");
        bus_rd(5'h0C, 16'h0000, "tstat_stopdone");
        bus_wr(5'h08, 16'h0008);
        bus_wr(5'h00, 16'h0002);
        tick();
        ac_done = 4'b0010; bus_wr(5'h04, 16'h0002); ac_done = '0;
        bus_rd(5'h02, 16'h0000, "busy_stop_wins");
        bus_rd(5'h06, 16'h0000, "hist_stop_wins");

        // TMO=0 never times out; restart then TMO=5 times out 5 cycles after restart
        bus_wr(5'h00, 16'h0001);
        repeat (70000) tick();
        bus_rd(5'h02, 16'h0001, "busy_long_run");
        bus_wr(5'h00, 16'h0001);
        bus_wr(5'h0A, 16'h0005);
        repeat (3) tick();
        bus_rd(5'h02, 16'h0001, "busy_restart_last");
        bus_rd(5'h02, 16'h0000, "busy_restart_tmo");
        bus_rd(5'h0C, 16'h0001, "tstat_restart");

        // Masking and undecoded reads
        bus_wr(5'h10, 16'hFFFF);
        bus_rd(5'h10, 16'h000F, "ien_mask");
        bus_wr(5'h0A, 16'h1234);
        bus_rd(5'h0A, 16'h1234, "tmo_rb");
        bus_wr(5'h0A, 16'h0000);
        bus_rd(5'h03, 16'h0000, "odd_addr");
        bus_rd(5'h0E, 16'h0000, "wo_addr");

        // Reset mid-operation with three channels running
        bus_wr(5'h00, 16'h000E);
        check("start_three", 16'(ac_start), 16'h000E);
        check("irq_pre_rst", 16'(irq), 16'h0001);
        rst = 1'b1;
        #1;
        check("async_start", 16'(ac_start), 16'h0000);
        check("async_irq", 16'(irq), 16'h0000);
        tick(); tick();
        rst = 1'b0;
        tick();
        bus_rd(5'h02, 16'h0000, "post_busy");
        bus_rd(5'h06, 16'h0000, "post_hist");
        bus_rd(5'h0A, 16'h0000, "post_tmo");
        bus_rd(5'h0C, 16'h0000, "post_tstat");
        bus_rd(5'h10, 16'h0000, "post_ien");
        bus_rd(5'h12, 16'h0000, "post_undec");
        bus_rd(5'h00, 16'h0000, "post_start_rd");
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
